// File: rtl/cdu_pkg.sv
// rtl/cdu_pkg.sv - shared scanner state type and default counter sizing
//
// Purpose: common definitions for the CDU error-counter bank.
// Ports: none (package).
package cdu_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    SEND = 1'b1
  } scan_state_e;

  localparam int CDU_DEFAULT_WIDTH = 10;
  localparam int CDU_DEFAULT_LIMIT = 384;

endpackage

// File: rtl/cdu_pulse_sync.sv
// rtl/cdu_pulse_sync.sv - synchronizer plus registered rising-edge detector for one pulse line
//
// Purpose: brings an asynchronous AGC count pulse into the clk domain and emits
//          one single-cycle event per rising edge.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  synchronous active-high reset
//   pulse_i  in  1  asynchronous pulse input
//   event_o  out 1  one-cycle count event
module cdu_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  output logic event_o
);

  localparam int FW = $clog2(SYNC_STAGES + 2);
  localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   event_q;
  logic [FW-1:0]          fill_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // After reset the chain and history hold reset zeros, not sampled input.
  // fill_q blocks edge detection until both the last stage and prev_q carry
  // real samples, so a pulse already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      event_q <= 1'b0;
      fill_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pulse_i};
      prev_q  <= level;
      event_q <= (fill_q == FILL_DONE) && level && !prev_q;
      if (fill_q != FILL_DONE) begin
        fill_q <= fill_q + FW'(1);
      end
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/cdu_error_counter_bank.sv
// rtl/cdu_error_counter_bank.sv - AGC error-counter bank with round-robin DAC scanner
//
// Purpose: per-channel saturating up/down counters driven by asynchronous
//          AGC pulses, plus a LOAD/SEND scanner presenting count snapshots.
// Ports:
//   clk        in  1         system clock
//   rst        in  1         synchronous active-high reset
//   pc_plus    in  CHANNELS  async +1 pulses
//   pc_minus   in  CHANNELS  async -1 pulses
//   eec        in  CHANNELS  per-channel counter enable (low holds count at 0)
//   zero       in  1         global clear of counts and overflow flags
//   dac_valid  out 1         scan word presented
//   dac_ready  in  1         downstream accepts word
//   dac_chan   out CW        channel index of presented word
//   dac_code   out WIDTH     snapshot of that channel's count
//   overflow   out CHANNELS  sticky saturation flags
module cdu_error_counter_bank
  import cdu_pkg::*;
#(
  parameter  int CHANNELS    = 3,
  parameter  int WIDTH       = CDU_DEFAULT_WIDTH,
  parameter  int LIMIT       = CDU_DEFAULT_LIMIT,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pc_plus,
  input  logic [CHANNELS-1:0] pc_minus,
  input  logic [CHANNELS-1:0] eec,
  input  logic                zero,
  output logic                dac_valid,
  input  logic                dac_ready,
  output logic [CW-1:0]       dac_chan,
  output logic [WIDTH-1:0]    dac_code,
  output logic [CHANNELS-1:0] overflow
);

  localparam logic signed [WIDTH-1:0] POS_LIM = WIDTH'(LIMIT);
  localparam logic signed [WIDTH-1:0] NEG_LIM = -POS_LIM;
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CW-1:0]           LAST_CH = CW'(CHANNELS - 1);

  logic [CHANNELS-1:0] plus_ev;
  logic [CHANNELS-1:0] minus_ev;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_sync
    cdu_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_plus (
      .clk     (clk),
      .rst     (rst),
      .pulse_i (pc_plus[c]),
      .event_o (plus_ev[c])
    );
    cdu_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_minus (
      .clk     (clk),
      .rst     (rst),
      .pulse_i (pc_minus[c]),
      .event_o (minus_ev[c])
    );
  end

  // ---------------------------------------------------------------- counters
  logic signed [WIDTH-1:0] count_q [CHANNELS];
  logic signed [WIDTH-1:0] count_d [CHANNELS];
  logic [CHANNELS-1:0]     ovf_q;
  logic [CHANNELS-1:0]     ovf_d;

  // Priority: zero, then eec, then events. Opposite events in one cycle cancel.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      count_d[c] = count_q[c];
      ovf_d[c]   = ovf_q[c];
      if (zero) begin
        count_d[c] = '0;
        ovf_d[c]   = 1'b0;
      end else if (!eec[c]) begin
        count_d[c] = '0;
      end else if (plus_ev[c] && !minus_ev[c]) begin
        if (count_q[c] == POS_LIM) begin
          ovf_d[c] = 1'b1;
        end else begin
          count_d[c] = count_q[c] + ONE;
        end
      end else if (minus_ev[c] && !plus_ev[c]) begin
        if (count_q[c] == NEG_LIM) begin
          ovf_d[c] = 1'b1;
        end else begin
          count_d[c] = count_q[c] - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        count_q[c] <= '0;
      end
      ovf_q <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;

  // ----------------------------------------------------------------- scanner
  scan_state_e      state_q;
  scan_state_e      state_d;
  logic [CW-1:0]    scan_ch_q;
  logic [CW-1:0]    scan_ch_d;
  logic [CW-1:0]    chan_q;
  logic [CW-1:0]    chan_d;
  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] code_d;

  always_comb begin
    state_d   = state_q;
    scan_ch_d = scan_ch_q;
    chan_d    = chan_q;
    code_d    = code_q;
    dac_valid = 1'b0;
    case (state_q)
      LOAD: begin
        // Snapshot taken here; later count changes wait for the next visit.
        code_d  = count_q[scan_ch_q];
        chan_d  = scan_ch_q;
        state_d = SEND;
      end
      SEND: begin
        dac_valid = 1'b1;
        if (dac_ready) begin
          scan_ch_d = (scan_ch_q == LAST_CH) ? '0 : scan_ch_q + CW'(1);
          state_d   = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      scan_ch_q <= '0;
      chan_q    <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      scan_ch_q <= scan_ch_d;
      chan_q    <= chan_d;
      code_q    <= code_d;
    end
  end

  assign dac_chan = chan_q;
  assign dac_code = code_q;

endmodule

// File: tb/tb_cdu_error_counter_bank.sv
// tb/tb_cdu_error_counter_bank.sv - self-checking bench for cdu_error_counter_bank
module tb_cdu_error_counter_bank;

  localparam int CH  = 3;
  localparam int W   = 10;
  localparam int LIM = 384;
  localparam int S   = 2;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] pc_plus;
  logic [CH-1:0] pc_minus;
  logic [CH-1:0] eec;
  logic          zero;
  logic          dac_valid;
  logic          dac_ready;
  logic [CW-1:0] dac_chan;
  logic [W-1:0]  dac_code;
  logic [CH-1:0] overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdu_error_counter_bank #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .LIMIT       (LIM),
    .SYNC_STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_plus   (pc_plus),
    .pc_minus  (pc_minus),
    .eec       (eec),
    .zero      (zero),
    .dac_valid (dac_valid),
    .dac_ready (dac_ready),
    .dac_chan  (dac_chan),
    .dac_code  (dac_code),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  // Counts as plain integers; an input rise sampled on cycle n takes effect
  // on cycle n+S+1. The scanner is described as "present a snapshot, hold it
  // until accepted, then one idle cycle, next channel".
  int            m_cnt [CH];
  bit [CH-1:0]   m_ovf;
  bit            m_valid;
  int            m_chan;
  int            m_code;
  int            m_next;
  bit [CH-1:0]   prev_p;
  bit [CH-1:0]   prev_m;
  bit            prev_ok;
  bit [CH-1:0]   due_p [int];
  bit [CH-1:0]   due_m [int];
  bit            live = 1'b0;

  initial begin
    int cyc;
    bit [CH-1:0] ep;
    bit [CH-1:0] em;
    bit [CH-1:0] tmp;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      ep = due_p.exists(cyc) ? due_p[cyc] : '0;
      em = due_m.exists(cyc) ? due_m[cyc] : '0;
      due_p.delete(cyc);
      due_m.delete(cyc);
      if (rst) begin
        for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        m_ovf   = '0;
        m_valid = 1'b0;
        m_chan  = 0;
        m_code  = 0;
        m_next  = 0;
        prev_ok = 1'b0;
        due_p.delete();
        due_m.delete();
        live    = 1'b1;
      end else begin
        if (!m_valid) begin
          m_valid = 1'b1;
          m_chan  = m_next;
          m_code  = m_cnt[m_next];
        end else if (dac_ready) begin
          m_valid = 1'b0;
          m_next  = (m_next + 1) % CH;
        end
        for (int c = 0; c < CH; c++) begin
          if (zero) begin
            m_cnt[c] = 0;
            m_ovf[c] = 1'b0;
          end else if (!eec[c]) begin
            m_cnt[c] = 0;
          end else if (ep[c] && !em[c]) begin
            if (m_cnt[c] == LIM) m_ovf[c] = 1'b1;
            else m_cnt[c] = m_cnt[c] + 1;
          end else if (em[c] && !ep[c]) begin
            if (m_cnt[c] == -LIM) m_ovf[c] = 1'b1;
            else m_cnt[c] = m_cnt[c] - 1;
          end
        end
        if (prev_ok) begin
          for (int c = 0; c < CH; c++) begin
            if (pc_plus[c] && !prev_p[c]) begin
              tmp = due_p.exists(cyc + S + 1) ? due_p[cyc + S + 1] : '0;
              tmp[c] = 1'b1;
              due_p[cyc + S + 1] = tmp;
            end
            if (pc_minus[c] && !prev_m[c]) begin
              tmp = due_m.exists(cyc + S + 1) ? due_m[cyc + S + 1] : '0;
              tmp[c] = 1'b1;
              due_m[cyc + S + 1] = tmp;
            end
          end
        end
        prev_p  = pc_plus;
        prev_m  = pc_minus;
        prev_ok = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        check("m_valid", dac_valid, m_valid);
        if (m_valid) begin
          check("m_chan", dac_chan, m_chan);
          check("m_code", $signed(dac_code), m_code);
        end
        check("m_ovf", overflow, m_ovf);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch, input bit p, input bit m, input int hi, input int lo);
    if (p) pc_plus[ch] = 1'b1;
    if (m) pc_minus[ch] = 1'b1;
    tick(hi);
    pc_plus[ch]  = 1'b0;
    pc_minus[ch] = 1'b0;
    tick(lo);
  endtask

  // Waits for a freshly loaded word of channel ch and returns its code.
  task automatic read_word(input int ch, output int code);
    int n;
    n    = 0;
    code = -9999;
    @(negedge clk);
    while (dac_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    while (!(dac_valid && dac_chan == CW'(ch)) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("read_word_timeout", 0, 1);
    else code = int'($signed(dac_code));
  endtask

  initial begin
    int c;
    int chan0;
    int code0;
    int n;

    rst       = 1'b1;
    pc_plus   = '0;
    pc_minus  = '0;
    eec       = '1;
    zero      = 1'b0;
    dac_ready = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_valid", dac_valid, 0);
    check("rst_chan", dac_chan, 0);
    check("rst_code", dac_code, 0);
    check("rst_ovf", overflow, 0);
    tick(1);
    rst = 1'b0;
    tick(6);

    // 1: five pulses on channel 1
    repeat (5) pulse(1, 1'b1, 1'b0, 3, 3);
    tick(8);
    read_word(1, c); check("s1_ch1", c, 5);
    read_word(0, c); check("s1_ch0", c, 0);
    read_word(2, c); check("s1_ch2", c, 0);

    // 2: saturation on channel 0
    repeat (400) pulse(0, 1'b1, 1'b0, 2, 2);
    tick(6);
    check("s2_ovf0", overflow[0], 1);
    read_word(0, c); check("s2_sat", c, 384);
    pulse(0, 1'b0, 1'b1, 2, 2);
    tick(6);
    read_word(0, c); check("s2_minus", c, 383);
    check("s2_ovf0_sticky", overflow[0], 1);

    // 3: cancellation and latency on channel 2
    tick(1);
    pulse(2, 1'b1, 1'b1, 3, 3);
    tick(6);
    check("s3_cancel", $signed(dut.count_q[2]), 0);
    read_word(2, c); check("s3_cancel_word", c, 0);
    @(posedge clk); #1;
    pc_plus[2] = 1'b1;
    @(posedge clk);
    repeat (S) @(posedge clk);
    @(negedge clk);
    check("s3_lat_before", $signed(dut.count_q[2]), 0);
    @(posedge clk);
    @(negedge clk);
    check("s3_lat_at", $signed(dut.count_q[2]), 1);
    @(posedge clk); #1;
    pc_plus[2] = 1'b0;
    tick(6);

    // 4: back-pressure freezes the presented word
    n = 0;
    @(negedge clk);
    while (!dac_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("s4_found_valid", dac_valid, 1);
    dac_ready = 1'b0;
    chan0 = int'(dac_chan);
    code0 = int'($signed(dac_code));
    fork
      begin
        @(posedge clk); #1;
        repeat (3) pulse(chan0, 1'b1, 1'b0, 2, 2);
      end
      begin
        repeat (20) begin
          @(negedge clk);
          check("s4_valid", dac_valid, 1);
          check("s4_chan", dac_chan, chan0);
          check("s4_code", $signed(dac_code), code0);
        end
      end
    join
    @(negedge clk);
    dac_ready = 1'b1;
    @(negedge clk);
    check("s4_gap", dac_valid, 0);
    @(negedge clk);
    check("s4_next_valid", dac_valid, 1);
    check("s4_next_chan", dac_chan, (chan0 + 1) % CH);
    tick(4);

    // 5: eec and zero clears
    repeat (45) pulse(1, 1'b1, 1'b0, 2, 2);
    tick(6);
    read_word(1, c); check("s5_ch1_50", c, 50);
    @(posedge clk); #1;
    eec[1] = 1'b0;
    tick(1);
    eec[1] = 1'b1;
    tick(2);
    read_word(1, c); check("s5_eec_clear", c, 0);
    check("s5_ovf_kept", overflow, 3'b001);
    pulse(2, 1'b1, 1'b0, 2, 2);
    tick(6);
    zero = 1'b1;
    tick(1);
    zero = 1'b0;
    tick(1);
    check("s5_zero_ovf", overflow, 0);
    read_word(0, c); check("s5_zero_ch0", c, 0);
    read_word(2, c); check("s5_zero_ch2", c, 0);

    // 6: reset during SEND with a pulse held high
    pulse(0, 1'b1, 1'b0, 2, 2);
    tick(6);
    n = 0;
    @(negedge clk);
    while (!dac_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    dac_ready = 1'b0;
    @(posedge clk); #1;
    pc_plus[0] = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    dac_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!dac_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("s6_first_chan", dac_chan, 0);
    check("s6_first_code", dac_code, 0);
    tick(10);
    pc_plus[0] = 1'b0;
    tick(6);
    read_word(0, c); check("s6_no_event", c, 0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
